score_event_scheduler: RTL

Sits between the game logic and score_board and is the only driver of its add, decr and isDecresing inputs. Food events and bonus awards are collected into a saturating pending-point counter. The counter is drained as single-cycle add pulses, spaced by a minimum gap. A periodic decay timer interleaves single-cycle decr pulses. The block freezes the score while paused and stops all activity once score_board reports gameover.

---
 rtl/score_event_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/score_event_scheduler.sv
// Score event scheduler: gathers eat/bonus points and periodic decay ticks, and
// issues them to score_board as spaced, single-cycle add/decr pulses.
module score_event_scheduler #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned GAP      = 2,
    parameter int unsigned PEND_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              decay_en,
    input  logic              eat,
    input  logic              bonus_valid,
    input  logic [3:0]        bonus_pts,
    input  logic              gameover,
    output logic              add,
    output logic              decr,
    output logic              isDecresing,
    output logic [PEND_W-1:0] pend_add,
    output logic              playing
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned SUM_W  = PEND_W + 2;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'({PEND_W{1'b1}});

    logic [1:0]        state, state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              decay_pend;

    logic [SUM_W-1:0]  avail, pend_sum;
    logic [PEND_W-1:0] pend_sat;
    logic              can_issue, issue_add, issue_decr;
    logic              tick_fire, playing_next;

    // Incoming points count toward this cycle's issue decision, giving one-cycle eat->add latency.
    always_comb begin
        avail = SUM_W'(pend_add) + SUM_W'(eat)
              + (bonus_valid ? SUM_W'(bonus_pts) : '0);
        can_issue  = (state == S_RUN) && !gameover && !pause && (gap_cnt == '0);
        issue_decr = can_issue && decay_pend;
        issue_add  = can_issue && !decay_pend && (avail != '0);
        pend_sum   = avail - SUM_W'(issue_add);
        pend_sat   = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
        tick_fire  = (state == S_RUN) && decay_en && (tick_cnt == TICK_W'(TICK_DIV - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_RUN;
            S_RUN:    if (gameover) state_next = S_OVER;
                      else if (pause) state_next = S_PAUSED;
            S_PAUSED: if (gameover) state_next = S_OVER;
                      else if (!pause) state_next = S_RUN;
            default:  state_next = S_OVER;
        endcase
        playing_next = (state_next == S_RUN) || (state_next == S_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            add         <= 1'b0;
            decr        <= 1'b0;
            isDecresing <= 1'b0;
            playing     <= 1'b0;
            pend_add    <= '0;
            decay_pend  <= 1'b0;
            tick_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_next;
            add         <= issue_add;
            decr        <= issue_decr;
            playing     <= playing_next;
            // Forced high on decr so it still qualifies a decrement issued after decay_en drops.
            isDecresing <= issue_decr | (decay_en & playing_next);

            if (issue_add || issue_decr)
                gap_cnt <= GAP_W'(GAP);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);

            if (state_next == S_OVER) begin
                pend_add   <= '0;
                decay_pend <= 1'b0;
                tick_cnt   <= '0;
            end else if (state == S_IDLE) begin
                if (start)
                    tick_cnt <= '0;
            end else begin
                pend_add <= pend_sat;
                if (state == S_RUN) begin
                    decay_pend <= tick_fire | (decay_pend & ~issue_decr);
                    if (decay_en)
                        tick_cnt <= tick_fire ? '0 : tick_cnt + TICK_W'(1);
                end
            end
        end
    end

endmodule
